// File: rtl/stereo_frame_buffer.sv
// rtl/stereo_frame_buffer.sv - stereo frame pairing, circular store and L/R word server for the DAC
//
// Purpose:
//   Pairs left/right channel words popped from the input FIFO into stereo frames,
//   stores them in a small circular buffer and serves them one channel word per
//   DAC pop in strict L,R order. The output stays muted (zeros) until PREFILL
//   frames are stored, falls back to mute on underrun, and drops whole frames on
//   overflow so the DAC never sees a torn or channel-swapped frame.
//
// Ports:
//   clk        in   system clock (clk491520 domain)
//   rst        in   asynchronous active-low reset
//   ack_i      in   [0]=left word strobe, [1]=right word strobe
//   data_i     in   [WIDTH-1:0]=left word, [2*WIDTH-1:WIDTH]=right word
//   pop_i      in   DAC request for the next channel word
//   data_o     out  channel word answering pop_i (one cycle later)
//   ack_o      out  data_o valid strobe
//   lrck_o     out  channel of data_o: 0=left, 1=right
//   level_o    out  frames currently stored
//   muted_o    out  high while zeros are being served
//   overflow_o out  sticky: a completed frame was dropped on a full store
//   pair_err_o out  sticky: orphan or duplicate channel word seen

module stereo_frame_buffer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int PREFILL    = 8,
    parameter int WIDTH      = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              ack_i,
    input  logic [2*WIDTH-1:0]      data_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    ack_o,
    output logic                    lrck_o,
    output logic [DEPTH_LOG2:0]     level_o,
    output logic                    muted_o,
    output logic                    overflow_o,
    output logic                    pair_err_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL    = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] PREFILL_LVL = (DEPTH_LOG2 + 1)'(PREFILL);

    typedef enum logic {WAIT_L, HAVE_L} pair_state_t;
    typedef enum logic {MUTE, PLAY}     out_state_t;

    pair_state_t            pair_st_q,  pair_st_d;
    out_state_t             out_st_q,   out_st_d;
    logic [WIDTH-1:0]       left_q,     left_d;
    logic                   wr_req_q,   wr_req_d;
    logic [2*WIDTH-1:0]     wr_frame_q, wr_frame_d;
    logic [DEPTH_LOG2-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [DEPTH_LOG2:0]    level_q,    level_d;
    logic                   overflow_q, overflow_d;
    logic                   pair_err_q, pair_err_d;
    logic                   phase_q,    phase_d;
    logic [WIDTH-1:0]       data_q,     data_d;
    logic                   ack_q,      ack_d;
    logic                   lrck_q,     lrck_d;
    logic                   muted_q,    muted_d;

    logic                   wr_en;
    logic                   rd_done;
    logic [2*WIDTH-1:0]     rd_frame;

    logic [2*WIDTH-1:0]     mem [DEPTH];

    assign rd_frame = mem[rd_ptr_q];

    always_comb begin
        pair_st_d  = pair_st_q;
        out_st_d   = out_st_q;
        left_d     = left_q;
        wr_req_d   = 1'b0;
        wr_frame_d = wr_frame_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        pair_err_d = pair_err_q;
        phase_d    = phase_q;
        data_d     = data_q;
        ack_d      = pop_i;
        lrck_d     = lrck_q;
        muted_d    = muted_q;
        wr_en      = 1'b0;
        rd_done    = 1'b0;

        // Input pairing: a frame is only formed from a left word followed by a right word.
        case (pair_st_q)
            WAIT_L: begin
                if (ack_i[0]) begin
                    left_d    = data_i[WIDTH-1:0];
                    pair_st_d = HAVE_L;
                end else if (ack_i[1]) begin
                    pair_err_d = 1'b1;
                end
            end
            HAVE_L: begin
                if (ack_i[1]) begin
                    wr_frame_d = {data_i[2*WIDTH-1:WIDTH], left_q};
                    wr_req_d   = 1'b1;
                    pair_st_d  = WAIT_L;
                end else if (ack_i[0]) begin
                    left_d     = data_i[WIDTH-1:0];
                    pair_err_d = 1'b1;
                end
            end
            default: pair_st_d = WAIT_L;
        endcase

        // Frame commit one cycle after the right strobe; whole frame dropped when full.
        if (wr_req_q) begin
            if (level_q == FULL_LVL) begin
                overflow_d = 1'b1;
            end else begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end

        // Output server. Mode changes only on a left pop so frames are never split.
        if (pop_i) begin
            lrck_d  = phase_q;
            phase_d = ~phase_q;
            data_d  = '0;
            if (!phase_q) begin
                if ((out_st_q == PLAY) ? (level_q != '0) : (level_q >= PREFILL_LVL)) begin
                    data_d   = rd_frame[WIDTH-1:0];
                    out_st_d = PLAY;
                    muted_d  = 1'b0;
                end else begin
                    out_st_d = MUTE;
                    muted_d  = 1'b1;
                end
            end else if (out_st_q == PLAY) begin
                // Right word completes the frame: release its slot.
                data_d   = rd_frame[2*WIDTH-1:WIDTH];
                rd_done  = 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end

        case ({wr_en, rd_done})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_frame_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pair_st_q  <= WAIT_L;
            out_st_q   <= MUTE;
            left_q     <= '0;
            wr_req_q   <= 1'b0;
            wr_frame_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            pair_err_q <= 1'b0;
            phase_q    <= 1'b0;
            data_q     <= '0;
            ack_q      <= 1'b0;
            lrck_q     <= 1'b0;
            muted_q    <= 1'b1;
        end else begin
            pair_st_q  <= pair_st_d;
            out_st_q   <= out_st_d;
            left_q     <= left_d;
            wr_req_q   <= wr_req_d;
            wr_frame_q <= wr_frame_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            pair_err_q <= pair_err_d;
            phase_q    <= phase_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            lrck_q     <= lrck_d;
            muted_q    <= muted_d;
        end
    end

    assign data_o     = data_q;
    assign ack_o      = ack_q;
    assign lrck_o     = lrck_q;
    assign level_o    = level_q;
    assign muted_o    = muted_q;
    assign overflow_o = overflow_q;
    assign pair_err_o = pair_err_q;

endmodule

// File: tb/tb_stereo_frame_buffer.sv
// tb/tb_stereo_frame_buffer.sv - directed self-checking bench for stereo_frame_buffer

module tb_stereo_frame_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  ack_i = 2'b00;
    logic [47:0] data_i = '0;
    logic        pop_i = 1'b0;
    logic [23:0] data_o;
    logic        ack_o;
    logic        lrck_o;
    logic [4:0]  level_o;
    logic        muted_o;
    logic        overflow_o;
    logic        pair_err_o;

    int checks = 0;
    int errors = 0;

    stereo_frame_buffer #(.DEPTH_LOG2(4), .PREFILL(8), .WIDTH(24)) dut (
        .clk(clk), .rst(rst), .ack_i(ack_i), .data_i(data_i), .pop_i(pop_i),
        .data_o(data_o), .ack_o(ack_o), .lrck_o(lrck_o), .level_o(level_o),
        .muted_o(muted_o), .overflow_o(overflow_o), .pair_err_o(pair_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    function automatic logic [23:0] exp_word(input int frame, input bit right);
        return right ? (24'h800000 + 24'(frame)) : (24'h000100 + 24'(frame));
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
        ack_i = 2'b01; data_i = {24'h0, l};
        tick;
        ack_i = 2'b10; data_i = {r, 24'h0};
        tick;
        ack_i = 2'b00; data_i = '0;
    endtask

    task automatic send_frames(input int first, input int count);
        for (int n = first; n < first + count; n++) send_pair(exp_word(n, 0), exp_word(n, 1));
        tick;
    endtask

    task automatic do_pop(output logic a, output logic [23:0] d, output logic lr, output logic m);
        pop_i = 1'b1;
        tick;
        pop_i = 1'b0;
        a = ack_o; d = data_o; lr = lrck_o; m = muted_o;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        tick;
        tick;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if (level_o !== 5'd0 || muted_o !== 1'b1 || ack_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_status level=%0d muted=%b ack=%b want 0 1 0", level_o, muted_o, ack_o);
        end
        checks++;
        if (data_o !== 24'h0 || lrck_o !== 1'b0 || overflow_o !== 1'b0 || pair_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_data data=%h lrck=%b ovf=%b perr=%b want 0 0 0 0", data_o, lrck_o, overflow_o, pair_err_o);
        end
    endtask

    task automatic test_prefill_play;
        logic a, lr, m;
        logic [23:0] d;
        do_reset;
        send_frames(0, 8);
        checks++;
        if (level_o !== 5'd8 || muted_o !== 1'b1 || ack_o !== 1'b0) begin
            errors++;
            $display("FAIL t1_prefilled level=%0d muted=%b ack=%b want 8 1 0", level_o, muted_o, ack_o);
        end
        for (int i = 0; i < 4; i++) begin
            do_pop(a, d, lr, m);
            checks++;
            if (a !== 1'b1 || d !== exp_word(i / 2, i % 2) || lr !== 1'((i % 2)) || m !== 1'b0) begin
                errors++;
                $display("FAIL t1_pop%0d ack=%b data=%h lrck=%b muted=%b want 1 %h %0d 0",
                         i, a, d, lr, m, exp_word(i / 2, i % 2), i % 2);
            end
        end
        tick;
        checks++;
        if (ack_o !== 1'b0 || level_o !== 5'd6) begin
            errors++;
            $display("FAIL t1_after ack=%b level=%0d want 0 6", ack_o, level_o);
        end
    endtask

    task automatic test_partial_prefill;
        logic a, lr, m;
        logic [23:0] d;
        do_reset;
        send_frames(0, 7);
        for (int i = 0; i < 4; i++) begin
            do_pop(a, d, lr, m);
            checks++;
            if (a !== 1'b1 || d !== 24'h0 || lr !== 1'((i % 2)) || m !== 1'b1) begin
                errors++;
                $display("FAIL t2_mute_pop%0d ack=%b data=%h lrck=%b muted=%b want 1 0 %0d 1", i, a, d, lr, m, i % 2);
            end
        end
        checks++;
        if (level_o !== 5'd7) begin
            errors++;
            $display("FAIL t2_level level=%0d want 7", level_o);
        end
        send_frames(7, 1);
        for (int i = 0; i < 2; i++) begin
            do_pop(a, d, lr, m);
            checks++;
            if (a !== 1'b1 || d !== exp_word(0, i % 2) || m !== 1'b0) begin
                errors++;
                $display("FAIL t2_play_pop%0d ack=%b data=%h muted=%b want 1 %h 0", i, a, d, m, exp_word(0, i % 2));
            end
        end
    endtask

    task automatic test_underrun;
        logic a, lr, m;
        logic [23:0] d;
        do_reset;
        send_frames(0, 8);
        for (int i = 0; i < 14; i++) do_pop(a, d, lr, m);
        for (int i = 0; i < 2; i++) begin
            do_pop(a, d, lr, m);
            checks++;
            if (d !== exp_word(7, i % 2) || m !== 1'b0) begin
                errors++;
                $display("FAIL t3_last_frame%0d data=%h muted=%b want %h 0", i, d, m, exp_word(7, i % 2));
            end
        end
        for (int i = 0; i < 2; i++) begin
            do_pop(a, d, lr, m);
            checks++;
            if (a !== 1'b1 || d !== 24'h0 || lr !== 1'((i % 2)) || m !== 1'b1 || level_o !== 5'd0) begin
                errors++;
                $display("FAIL t3_underrun%0d ack=%b data=%h lrck=%b muted=%b level=%0d want 1 0 %0d 1 0",
                         i, a, d, lr, m, level_o, i % 2);
            end
        end
        send_frames(8, 7);
        for (int i = 0; i < 2; i++) begin
            do_pop(a, d, lr, m);
            checks++;
            if (d !== 24'h0 || m !== 1'b1) begin
                errors++;
                $display("FAIL t3_refill%0d data=%h muted=%b want 0 1", i, d, m);
            end
        end
        send_frames(15, 1);
        do_pop(a, d, lr, m);
        checks++;
        if (d !== exp_word(8, 0) || m !== 1'b0 || lr !== 1'b0) begin
            errors++;
            $display("FAIL t3_resume data=%h muted=%b lrck=%b want %h 0 0", d, m, lr, exp_word(8, 0));
        end
    endtask

    task automatic test_overflow_pairing;
        logic a, lr, m;
        logic [23:0] d;
        int bad;
        do_reset;
        send_frames(0, 17);
        checks++;
        if (level_o !== 5'd16 || overflow_o !== 1'b1 || pair_err_o !== 1'b0) begin
            errors++;
            $display("FAIL t4_full level=%0d ovf=%b perr=%b want 16 1 0", level_o, overflow_o, pair_err_o);
        end
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            do_pop(a, d, lr, m);
            if (d !== exp_word(i / 2, i % 2)) bad++;
        end
        checks++;
        if (bad != 0 || level_o !== 5'd0) begin
            errors++;
            $display("FAIL t4_readback bad_words=%0d level=%0d want 0 0", bad, level_o);
        end
        do_pop(a, d, lr, m);
        checks++;
        if (d !== 24'h0 || m !== 1'b1) begin
            errors++;
            $display("FAIL t4_no_17th data=%h muted=%b want 0 1", d, m);
        end

        do_reset;
        ack_i = 2'b10; data_i = {24'h0DEAD1, 24'h0};
        tick;
        ack_i = 2'b00;
        tick;
        checks++;
        if (pair_err_o !== 1'b1 || level_o !== 5'd0) begin
            errors++;
            $display("FAIL t4_orphan_right perr=%b level=%0d want 1 0", pair_err_o, level_o);
        end
        ack_i = 2'b01; data_i = {24'h0, 24'h0AAAAA};
        tick;
        ack_i = 2'b01; data_i = {24'h0, 24'h0BBBBB};
        tick;
        ack_i = 2'b10; data_i = {24'h0CCCCC, 24'h0};
        tick;
        ack_i = 2'b00; data_i = '0;
        send_frames(1, 7);
        checks++;
        if (level_o !== 5'd8) begin
            errors++;
            $display("FAIL t4_pair_level level=%0d want 8", level_o);
        end
        do_pop(a, d, lr, m);
        checks++;
        if (d !== 24'h0BBBBB) begin
            errors++;
            $display("FAIL t4_dup_left data=%h want 0bbbbb", d);
        end
        do_pop(a, d, lr, m);
        checks++;
        if (d !== 24'h0CCCCC) begin
            errors++;
            $display("FAIL t4_dup_right data=%h want 0ccccc", d);
        end
    endtask

    task automatic test_back_to_back;
        logic a, lr, m;
        logic [23:0] d;
        do_reset;
        send_frames(0, 10);
        checks++;
        if (level_o !== 5'd10) begin
            errors++;
            $display("FAIL t5_level10 level=%0d want 10", level_o);
        end
        do_pop(a, d, lr, m);
        ack_i = 2'b01; data_i = {24'h0, exp_word(10, 0)};
        tick;
        ack_i = 2'b10; data_i = {exp_word(10, 1), 24'h0};
        tick;
        ack_i = 2'b00; data_i = '0;
        pop_i = 1'b1;
        tick;
        pop_i = 1'b0;
        checks++;
        if (ack_o !== 1'b1 || data_o !== exp_word(0, 1) || level_o !== 5'd10) begin
            errors++;
            $display("FAIL t5_simul ack=%b data=%h level=%0d want 1 %h 10", ack_o, data_o, level_o, exp_word(0, 1));
        end
        pop_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            checks++;
            if (ack_o !== 1'b1 || data_o !== exp_word(1 + i / 2, i % 2) || lrck_o !== 1'((i % 2))) begin
                errors++;
                $display("FAIL t5_b2b%0d ack=%b data=%h lrck=%b want 1 %h %0d",
                         i, ack_o, data_o, lrck_o, exp_word(1 + i / 2, i % 2), i % 2);
            end
        end
        pop_i = 1'b0;
        tick;
        checks++;
        if (ack_o !== 1'b0 || level_o !== 5'd7) begin
            errors++;
            $display("FAIL t5_b2b_end ack=%b level=%0d want 0 7", ack_o, level_o);
        end
        for (int i = 0; i < 12; i++) do_pop(a, d, lr, m);
        for (int i = 0; i < 2; i++) begin
            do_pop(a, d, lr, m);
            checks++;
            if (d !== exp_word(10, i % 2)) begin
                errors++;
                $display("FAIL t5_frame10_%0d data=%h want %h", i, d, exp_word(10, i % 2));
            end
        end
    endtask

    task automatic test_async_reset;
        logic a, lr, m;
        logic [23:0] d;
        do_reset;
        send_frames(0, 8);
        do_pop(a, d, lr, m);
        ack_i = 2'b01; data_i = {24'h0, 24'h0EEEEE};
        tick;
        ack_i = 2'b00; data_i = '0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (level_o !== 5'd0 || muted_o !== 1'b1 || data_o !== 24'h0 || ack_o !== 1'b0 ||
            lrck_o !== 1'b0 || overflow_o !== 1'b0 || pair_err_o !== 1'b0) begin
            errors++;
            $display("FAIL t6_async level=%0d muted=%b data=%h ack=%b lrck=%b ovf=%b perr=%b want 0 1 0 0 0 0 0",
                     level_o, muted_o, data_o, ack_o, lrck_o, overflow_o, pair_err_o);
        end
        tick;
        tick;
        rst = 1'b1;
        ack_i = 2'b10; data_i = {24'h0FFFF1, 24'h0};
        tick;
        ack_i = 2'b00; data_i = '0;
        tick;
        checks++;
        if (pair_err_o !== 1'b1 || level_o !== 5'd0) begin
            errors++;
            $display("FAIL t6_wait_l perr=%b level=%0d want 1 0", pair_err_o, level_o);
        end
        send_frames(0, 7);
        do_pop(a, d, lr, m);
        checks++;
        if (d !== 24'h0 || m !== 1'b1) begin
            errors++;
            $display("FAIL t6_still_muted data=%h muted=%b want 0 1", d, m);
        end
        do_pop(a, d, lr, m);
        send_frames(7, 1);
        do_pop(a, d, lr, m);
        checks++;
        if (d !== exp_word(0, 0) || m !== 1'b0) begin
            errors++;
            $display("FAIL t6_unmute data=%h muted=%b want %h 0", d, m, exp_word(0, 0));
        end
    endtask

    initial begin
        test_reset;
        test_prefill_play;
        test_partial_prefill;
        test_underrun;
        test_overflow_pairing;
        test_back_to_back;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
